matmul_sched: RTL and testbench
===============================

// Module: matmul_sched
// PURPOSE
//  Sequences the shared radix-4 Booth Multiplier to compute C = A x B for NxN signed 16-bit matrices.
//  Per element C[i][j]: loads N operand pairs into the operand FIFOs and starts the Multiplier.
//  Then drains its N products from the result FIFO, accumulates them, writes C[i][j] and clears the Multiplier.
//  Sits between the matrix top-level control/memories and the Multiplier + its three FIFOs.
// PARAMETERS
//  N    4  matrix dimension; legal 1..8 (operand/result FIFO depth is 8)
//  AW   4  address width of A/B/C memories; must satisfy 2**AW >= N*N
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset_n      in   1   asynchronous active-low reset
//  op_start     in   1   start a full matrix multiply (sampled in IDLE only)
//  op_clear     in   1   abort/clear; valid in any state
//  op_done      out  1   level-high when all N*N results are written
//  a_addr       out  AW  A read address, row-major (i*N+k)
//  b_addr       out  AW  B read address, row-major (k*N+j)
//  a_rdata      in   16  A read data, 1-cycle latency after a_addr
//  b_rdata      in   16  B read data, 1-cycle latency after b_addr
//  opnd_we      out  1   push strobe to both operand FIFOs
//  cand_din     out  16  multiplicand FIFO write data (= A element)
//  plier_din    out  16  multiplier FIFO write data (= B element)
//  res_re       out  1   pop strobe to result FIFO; data valid next cycle
//  res_dout     in   32  result FIFO read data (signed product)
//  res_empty    in   1   result FIFO empty flag
//  multi_opstart out 1   one-cycle start pulse to Multiplier
//  multi_opclear out 1   one-cycle clear pulse to Multiplier
//  multi_opdone in   1   Multiplier done level
//  fifo_flush   out  1   one-cycle synchronous flush of all three FIFOs
//  c_we         out  1   C memory write strobe
//  c_addr       out  AW  C write address (i*N+j)
//  c_wdata      out  32  C write data (accumulated dot product)
// BEHAVIOUR
//  Reset: state IDLE; i=j=k=0; acc=0; every output 0.
//  FSM states and transitions:
//   IDLE: op_start -> LOAD.
//   LOAD: N+1 cycles. Issues addr k=0..N-1 on cycles 0..N-1; opnd_we=1 on cycles 1..N with rdata -> DIN; then START.
//   START: multi_opstart=1 for exactly 1 cycle -> WAIT.
//   WAIT: multi_opdone=1 -> DRAIN.
//   DRAIN: issues res_re only when !res_empty and pops<N.
//    On the cycle after each res_re: acc += signed res_dout, mod 2**32 (wrap, no saturation).
//    After N accumulations -> WRITE.
//   WRITE: c_we=1, c_addr=i*N+j, c_wdata=acc for 1 cycle -> NEXT.
//   NEXT: multi_opclear=1 for 1 cycle; acc<=0.
//    j increments first; when j wraps to 0, i increments.
//    If i=N-1 and j=N-1 -> DONE, else -> LOAD.
//   DONE: op_done=1; op_start ignored; stays until op_clear.
//   CLEAR (any state on op_clear=1): multi_opclear=1 and fifo_flush=1 for 1 cycle; i=j=k=acc=0 -> IDLE.
//  op_clear has priority over every other transition, including a simultaneous op_start.
//  Outputs not driven by the current state are 0. The *_din buses hold their last value.
//  Async reset mid-operation: immediate return to reset values. FIFOs are not flushed by this block on reset.
//  Operand FIFOs are empty at each LOAD (N<=8), so no full check is performed.
//  res_empty gaps stall DRAIN without losing count.
//  Per-element cycle count, excluding WAIT and empty stalls: (N+1)+1+(N+1)+1+1.
// TESTING
//  N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C writes 19,22,43,50 at addr 0,1,2,3; then op_done=1.
//  Signed: N=2, A=[[-1,-2],[3,0]], B=[[-1,4],[5,-6]] -> C = -9,8,-3,12 (32-bit two's complement).
//  Wrap: N=1, A=B=0x8000 -> C[0]=0x40000000. N=2 all 0x8000 -> 0x80000000 (wrap, no saturation).
//  Hold multi_opdone low 20 cycles after start -> no res_re/c_we until it rises.
//   Insert res_empty=1 gaps in DRAIN -> same C result.
//  op_clear during WAIT of element 1 -> one-cycle multi_opclear+fifo_flush, IDLE next, no c_we.
//   Then op_start gives a fresh full run.
//  reset_n low during DRAIN -> all outputs 0 asynchronously; op_start after release restarts at C[0].

Source files
------------

// File: rtl/matmul_sched.sv
// matmul_sched: sequences the shared Booth multiplier and its FIFOs
// to compute C = A x B for NxN signed 16-bit matrices.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   op_start/op_clear     start a multiply / abort from any state
//   op_done               level-high once all N*N results are written
//   a_addr/b_addr         A/B read addresses (1-cycle read latency)
//   a_rdata/b_rdata       A/B read data
//   opnd_we               push strobe to both operand FIFOs
//   cand_din/plier_din    operand FIFO write data (hold last value)
//   res_re                result FIFO pop (data valid next cycle)
//   res_dout/res_empty    result FIFO data / empty flag
//   multi_opstart/opclear one-cycle multiplier start / clear pulses
//   multi_opdone          multiplier done level
//   fifo_flush            one-cycle flush of all three FIFOs
//   c_we/c_addr/c_wdata   C memory write port
module matmul_sched #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_clear,
  output logic          op_done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [15:0]   a_rdata,
  input  logic [15:0]   b_rdata,
  output logic          opnd_we,
  output logic [15:0]   cand_din,
  output logic [15:0]   plier_din,
  output logic          res_re,
  input  logic [31:0]   res_dout,
  input  logic          res_empty,
  output logic          multi_opstart,
  output logic          multi_opclear,
  input  logic          multi_opdone,
  output logic          fifo_flush,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [31:0]   c_wdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_CLEAR
  } state_e;

  localparam int CW = 4;
  localparam logic [CW-1:0] NL  = CW'(N);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  state_e state_q, state_d;

  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  // k: operand index in LOAD, pop count in DRAIN
  logic [CW-1:0] k_q, k_d;
  // n: accumulations done in DRAIN
  logic [CW-1:0] n_q, n_d;
  logic [31:0]   acc_q, acc_d;
  // pop issued last cycle -> res_dout valid now
  logic          rv_q, rv_d;
  logic [15:0]   cand_q, plier_q;

  function automatic logic [AW-1:0] idx(
    input logic [CW-1:0] r,
    input logic [CW-1:0] c
  );
    return AW'(32'(r) * 32'(N) + 32'(c));
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      rv_q    <= 1'b0;
      cand_q  <= '0;
      plier_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      rv_q    <= rv_d;
      if (opnd_we) begin
        cand_q  <= a_rdata;
        plier_q <= b_rdata;
      end
    end
  end

  // read data goes straight through on the push cycle, held otherwise
  assign cand_din  = opnd_we ? a_rdata : cand_q;
  assign plier_din = opnd_we ? b_rdata : plier_q;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    n_d           = n_q;
    acc_d         = acc_q;
    rv_d          = 1'b0;
    op_done       = 1'b0;
    a_addr        = '0;
    b_addr        = '0;
    opnd_we       = 1'b0;
    res_re        = 1'b0;
    multi_opstart = 1'b0;
    multi_opclear = 1'b0;
    fifo_flush    = 1'b0;
    c_we          = 1'b0;
    c_addr        = '0;
    c_wdata       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (op_start) begin
          state_d = S_LOAD;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_LOAD: begin
        if (k_q < NL) begin
          a_addr = idx(i_q, k_q);
          b_addr = idx(k_q, j_q);
        end
        // data for address k arrives on cycle k+1
        opnd_we = (k_q != '0);
        if (k_q == NL) begin
          state_d = S_START;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_START: begin
        multi_opstart = 1'b1;
        state_d       = S_WAIT;
        k_d           = '0;
        n_d           = '0;
      end
      S_WAIT: begin
        if (multi_opdone) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_re = !res_empty && (k_q < NL);
        rv_d   = res_re;
        if (res_re) begin
          k_d = k_q + 1'b1;
        end
        if (rv_q) begin
          acc_d = acc_q + res_dout;
          n_d   = n_q + 1'b1;
          if (n_q == NM1) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        c_we    = 1'b1;
        c_addr  = idx(i_q, j_q);
        c_wdata = acc_q;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        multi_opclear = 1'b1;
        acc_d         = '0;
        k_d           = '0;
        if (j_q == NM1) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (i_q == NM1 && j_q == NM1) begin
          state_d = S_DONE;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        op_done = 1'b1;
      end
      S_CLEAR: begin
        multi_opclear = 1'b1;
        fifo_flush    = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort wins over every other transition
    if (op_clear) begin
      state_d = S_CLEAR;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      n_d     = '0;
      acc_d   = '0;
      rv_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: scoreboard bench for matmul_sched (N=2)
// with a behavioural multiplier/FIFO/memory model.
module tb_matmul_sched;

  localparam int N  = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          op_start = 1'b0;
  logic          op_clear = 1'b0;
  logic          op_done;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [15:0]   a_rdata, b_rdata, cand_din, plier_din;
  logic          opnd_we, res_re, res_empty;
  logic [31:0]   res_dout, c_wdata;
  logic          multi_opstart, multi_opclear, multi_opdone;
  logic          fifo_flush, c_we;

  matmul_sched #(.N(N), .AW(AW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .op_start(op_start), .op_clear(op_clear),
    .op_done(op_done),
    .a_addr(a_addr), .b_addr(b_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .opnd_we(opnd_we),
    .cand_din(cand_din), .plier_din(plier_din),
    .res_re(res_re), .res_dout(res_dout),
    .res_empty(res_empty),
    .multi_opstart(multi_opstart),
    .multi_opclear(multi_opclear),
    .multi_opdone(multi_opdone),
    .fifo_flush(fifo_flush),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  longint cyc = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // ---------------- environment model ----------------
  logic [15:0] am [N*N];
  logic [15:0] bm [N*N];
  logic [15:0] cq [$];
  logic [15:0] pq [$];
  logic [31:0] rq [$];
  int dly_cfg = 0;
  int cnt = 0;
  bit pend = 0;
  bit gaps_en = 0;
  logic signed [15:0] m_ca, m_pl;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cq.delete(); pq.delete(); rq.delete();
      pend = 0;
      a_rdata <= '0; b_rdata <= '0; res_dout <= '0;
      multi_opdone <= 1'b0; res_empty <= 1'b1;
    end else begin
      a_rdata <= am[a_addr];
      b_rdata <= bm[b_addr];
      if (res_re) begin
        chk("pop_legal",
            32'(rq.size() != 0 && multi_opdone), 32'd1);
        if (rq.size() != 0) res_dout <= rq.pop_front();
      end
      if (fifo_flush) begin
        cq.delete(); pq.delete(); rq.delete();
      end else if (opnd_we) begin
        cq.push_back(cand_din);
        pq.push_back(plier_din);
      end
      if (multi_opclear) begin
        multi_opdone <= 1'b0;
        pend = 0;
      end else if (multi_opstart) begin
        pend = 1;
        cnt = dly_cfg;
      end else if (pend) begin
        if (cnt == 0) begin
          while (cq.size() != 0) begin
            m_ca = cq.pop_front();
            m_pl = pq.pop_front();
            rq.push_back(32'(int'(m_ca) * int'(m_pl)));
          end
          multi_opdone <= 1'b1;
          pend = 0;
        end else begin
          cnt--;
        end
      end
      res_empty <= (rq.size() == 0) ||
                   (gaps_en && $urandom_range(0, 2) == 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [33:0] expq [$];
  logic [33:0] mon_e;
  longint st_times [$];
  int nwe = 0;
  int ncwe = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (multi_opstart) st_times.push_back(cyc);
      if (opnd_we) nwe++;
      if (c_we) begin
        ncwe++;
        if (expq.size() == 0) begin
          chk("c_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("c_addr", 32'(c_addr), 32'(mon_e[33:32]));
          chk("c_data", c_wdata, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- reference and tasks ----------------
  task automatic push_exp();
    int s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(am[r*N+k])) * int'($signed(bm[k*N+c]));
        expq.push_back({AW'(r*N+c), 32'(s)});
      end
  endtask

  function automatic logic any_out();
    return |{op_done, a_addr, b_addr, opnd_we, cand_din, plier_din,
             res_re, multi_opstart, multi_opclear, fifo_flush,
             c_we, c_addr, c_wdata};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 op_start = 1'b1;
    @(posedge clk); #1 op_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!op_done && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", 32'(op_done), 32'd1);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 op_clear = 1'b1;
    @(posedge clk); #1 op_clear = 1'b0;
    chk("clr_pulse", 32'({multi_opclear, fifo_flush}), 32'd3);
    @(posedge clk); #1;
    chk("clr_idle", 32'({multi_opclear, fifo_flush, op_done}), 32'd0);
  endtask

  task automatic run_mm(input int dly, input bit gaps);
    int si;
    dly_cfg = dly;
    gaps_en = gaps;
    push_exp();
    si = st_times.size();
    pulse_start();
    wait_done();
    chk("exp_drained", 32'(expq.size()), 32'd0);
    if (!gaps && st_times.size() >= si + 2)
      chk("elem_period", 32'(st_times[si+1] - st_times[si]),
          32'(2*(N+1) + 5 + dly));
    else if (!gaps)
      chk("elem_period_seen", 32'(st_times.size()), 32'(si + 2));
  endtask

  task automatic set_mats(input logic [15:0] a [N*N],
                          input logic [15:0] b [N*N]);
    for (int x = 0; x < N*N; x++) begin
      am[x] = a[x];
      bm[x] = b[x];
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: return 16'h8000;
      1: return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_mats();
    for (int x = 0; x < N*N; x++) begin
      am[x] = rnd16();
      bm[x] = rnd16();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ta [N*N];
    logic [15:0] tb [N*N];
    int we0, cwe0, t;

    for (int x = 0; x < N*N; x++) begin
      am[x] = '0; bm[x] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(any_out()), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs", 32'(any_out()), 32'd0);

    // basic
    ta = '{16'd1, 16'd2, 16'd3, 16'd4};
    tb = '{16'd5, 16'd6, 16'd7, 16'd8};
    set_mats(ta, tb);
    run_mm(0, 0);
    // op_start ignored in DONE
    we0 = nwe;
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", 32'(op_done), 32'd1);
    chk("done_no_load", 32'(nwe - we0), 32'd0);
    do_clear();

    // signed
    ta = '{16'hffff, 16'hfffe, 16'd3, 16'd0};
    tb = '{16'hffff, 16'd4, 16'd5, 16'hfffa};
    set_mats(ta, tb);
    run_mm(1, 0);
    do_clear();

    // wrap
    ta = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    set_mats(ta, ta);
    run_mm(0, 0);
    do_clear();

    // long multiplier latency, then gaps
    rand_mats();
    run_mm(20, 0);
    do_clear();
    rand_mats();
    run_mm(3, 1);
    do_clear();

    // abort during WAIT of element 1
    rand_mats();
    dly_cfg = 20;
    gaps_en = 0;
    push_exp();
    we0 = st_times.size();
    pulse_start();
    t = 0;
    while (st_times.size() < we0 + 2 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("elem1_started", 32'(st_times.size()), 32'(we0 + 2));
    repeat (5) @(posedge clk);
    #1 op_clear = 1'b1;
    expq.delete();
    cwe0 = ncwe;
    @(posedge clk); #1 op_clear = 1'b0;
    chk("abort_pulse", 32'({multi_opclear, fifo_flush}), 32'd3);
    @(posedge clk); #1;
    chk("abort_idle", 32'({multi_opclear, fifo_flush, op_done}), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_cwe", 32'(ncwe - cwe0), 32'd0);
    run_mm(2, 0);
    do_clear();

    // async reset during DRAIN
    rand_mats();
    dly_cfg = 4;
    gaps_en = 1;
    push_exp();
    pulse_start();
    t = 0;
    we0 = 0;
    while (t < 500 && we0 == 0) begin
      @(negedge clk);
      if (res_re) we0 = 1;
      t++;
    end
    chk("drain_seen", 32'(we0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'(any_out()), 32'd0);
    expq.delete();
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    run_mm(0, 0);
    do_clear();

    // random runs
    for (int r = 0; r < 6; r++) begin
      rand_mats();
      run_mm(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
      do_clear();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
